pipe_hazard_ctrl: RTL and testbench

- Pipeline control unit for the RV32I 5-stage core (IF/ID/EX/MEM/WB).
- Detects load-use hazards against the decode stage and squashes wrong-path instructions on taken branches.
- Freezes the pipeline while the data memory handshake is pending, and escalates a hung memory access to a sticky error.
- Sits beside the decode, execute and memory stages; drives the stall and flush inputs of every pipeline register and the PC redirect.

---
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for the RV32I 5-stage core (IF/ID/EX/MEM/WB).
// Detects load-use hazards against decode, squashes wrong-path instructions
// on taken branches, freezes the pipe while a data-memory access is pending,
// and turns a hung memory access into a sticky error.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   id_reg1_read/addr    decode rs1 usage and address
//   id_reg2_read/addr    decode rs2 usage and address
//   ex_rmem, ex_wreg     EX instruction is a load / writes rd
//   ex_wd                EX destination register
//   ex_branch_taken      EX branch/jump resolved taken
//   ex_branch_target     resolved target PC
//   mem_req, mem_ready   MEM data-memory handshake
//   stall[5:0]           freeze: [0] PC [1] IF/ID [2] ID/EX [3] EX/MEM
//                        [4] MEM/WB [5] WB
//   flush_if_id/id_ex    bubble into IF/ID and ID/EX
//   redirect_valid/pc    PC redirect
//   mem_err              sticky memory timeout error
//   stall_cnt, flush_cnt saturating performance counters
//
// stall/flush/redirect are combinational (same-cycle effect); state, the
// wait counter, mem_err and the counters are registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic [4:0]       id_reg2_addr,
  input  logic             ex_rmem,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_wd,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [5:0]       stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  // Everything upstream of WB freezes; WB keeps draining.
  localparam logic [5:0] STALL_MEM = 6'b011111;
  // PC, IF/ID and ID/EX hold; ID/EX also takes a bubble.
  localparam logic [5:0] STALL_LU  = 6'b000111;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            mem_wait;
  logic            load_use;
  logic            mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Next state and memory-wait detection.
  // wait_cnt holds the number of stall cycles already spent on the current
  // access, so ERROR is entered on the cycle that would make it MEM_TIMEOUT.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    wait_nxt  = wait_cnt;
    mem_wait  = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_wait  = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          mem_wait = 1'b1;
          wait_nxt = wait_cnt + WC_W'(1);
          if (wait_nxt >= WC_MAX) state_nxt = ERROR;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_rmem && ex_wreg && (ex_wd != 5'd0) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));

  // Control outputs, priority: ERROR > memory wait > branch > load-use.
  // A taken branch squashes the ID instruction, which makes any load-use
  // hazard on it moot.
  always_comb begin
    stall          = '0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      if (state == ERROR || mem_wait) begin
        stall = STALL_MEM;
      end else if (ex_branch_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_branch_target;
        flush_if_id    = 1'b1;
        flush_id_ex    = 1'b1;
      end else if (load_use) begin
        stall       = STALL_LU;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ERROR) mem_err_q <= 1'b1;
      if (stall[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_valid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs read as zero for the whole time reset is held.
  assign mem_err   = mem_err_q & ~rst;
  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4. Each step drives
// inputs on the falling edge, queues the expected control outputs, then pops
// and compares them before the next rising edge. Registered outputs
// (mem_err, counters) are compared directly against bench-computed values.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_reg1_read, id_reg2_read;
  logic [4:0]       id_reg1_addr, id_reg2_addr;
  logic             ex_rmem, ex_wreg;
  logic [4:0]       ex_wd;
  logic             ex_branch_taken;
  logic [31:0]      ex_branch_target;
  logic             mem_req, mem_ready;
  logic [5:0]       stall;
  logic             flush_if_id, flush_id_ex, redirect_valid;
  logic [31:0]      redirect_pc;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_reg1_read     (id_reg1_read),
    .id_reg2_read     (id_reg2_read),
    .id_reg1_addr     (id_reg1_addr),
    .id_reg2_addr     (id_reg2_addr),
    .ex_rmem          (ex_rmem),
    .ex_wreg          (ex_wreg),
    .ex_wd            (ex_wd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .stall            (stall),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_err          (mem_err),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [5:0] S_MEM = 6'b011111;
  localparam logic [5:0] S_LU  = 6'b000111;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [5:0] s, input logic fif,
                                       input logic fie, input logic rv,
                                       input logic [31:0] pc);
    return {23'd0, s, fif, fie, rv, pc};
  endfunction

  // Queue the expected control word, then compare once outputs settle.
  task automatic expect_out(input string tag, input logic [5:0] s, input logic fif,
                            input logic fie, input logic rv, input logic [31:0] pc);
    exp_t e;
    q.push_back('{tag: tag, val: pack(s, fif, fie, rv, pc)});
    #1;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      check(e.tag, pack(stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc), e.val);
    end
  endtask

  task automatic idle();
    id_reg1_read = 0; id_reg2_read = 0; id_reg1_addr = 0; id_reg2_addr = 0;
    ex_rmem = 0; ex_wreg = 0; ex_wd = 0;
    ex_branch_taken = 0; ex_branch_target = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load(input logic [4:0] wd, input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
    ex_rmem = 1; ex_wreg = 1; ex_wd = wd;
    id_reg1_read = r1; id_reg1_addr = a1;
    id_reg2_read = r2; id_reg2_addr = a2;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(negedge clk);

    // Reset masks every output even with hazards on the inputs.
    set_load(5'd5, 0, 0, 1, 5'd5);
    ex_branch_taken = 1; ex_branch_target = 32'h40;
    mem_req = 1;
    expect_out("rst_mask", 6'd0, 0, 0, 0, 32'd0);
    check("rst_mem_err", 64'(mem_err), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);

    // Load-use via rs2: one stall cycle, then EX holds the bubble.
    @(negedge clk); rst = 0; idle();
    set_load(5'd5, 0, 0, 1, 5'd5);
    expect_out("lu_rs2", S_LU, 0, 1, 0, 32'd0);
    @(negedge clk); idle();
    expect_out("lu_bubble", 6'd0, 0, 0, 0, 32'd0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);

    // x0 destination and unread operand never stall.
    @(negedge clk); idle(); set_load(5'd0, 1, 5'd0, 0, 0);
    expect_out("lu_x0", 6'd0, 0, 0, 0, 32'd0);
    @(negedge clk); idle(); set_load(5'd7, 0, 5'd7, 0, 5'd7);
    expect_out("lu_noread", 6'd0, 0, 0, 0, 32'd0);
    // Non-load writer with a match does not stall either.
    @(negedge clk); idle(); set_load(5'd9, 1, 5'd9, 0, 0); ex_rmem = 0;
    expect_out("lu_notload", 6'd0, 0, 0, 0, 32'd0);
    @(negedge clk); idle(); set_load(5'd7, 1, 5'd7, 0, 0);
    expect_out("lu_rs1", S_LU, 0, 1, 0, 32'd0);

    // Branch wins over a simultaneous load-use.
    @(negedge clk); idle(); set_load(5'd5, 0, 0, 1, 5'd5);
    ex_branch_taken = 1; ex_branch_target = 32'h0000_0100;
    expect_out("br_lu", 6'd0, 1, 1, 1, 32'h100);
    @(negedge clk); idle();
    expect_out("br_after", 6'd0, 0, 0, 0, 32'd0);
    check("br_flush_cnt", 64'(flush_cnt), 64'd1);
    check("br_stall_cnt", 64'(stall_cnt), 64'd2);

    // Single-cycle memory access: no stall.
    @(negedge clk); idle(); mem_req = 1; mem_ready = 1;
    expect_out("mem_1cyc", 6'd0, 0, 0, 0, 32'd0);

    // Three wait cycles with a pending branch, released on ready.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); mem_req = 1;
      ex_branch_taken = 1; ex_branch_target = 32'h200;
      expect_out($sformatf("mem_wait%0d", i), S_MEM, 0, 0, 0, 32'd0);
    end
    @(negedge clk); mem_ready = 1;
    expect_out("mem_ready", 6'd0, 1, 1, 1, 32'h200);
    // Back in RUN: a plain load-use is honoured again.
    @(negedge clk); idle(); set_load(5'd3, 1, 5'd3, 0, 0);
    expect_out("mem_run", S_LU, 0, 1, 0, 32'd0);
    check("mem_stall_cnt", 64'(stall_cnt), 64'd5);
    check("mem_flush_cnt", 64'(flush_cnt), 64'd2);

    // Timeout: four stall cycles without error, then sticky ERROR.
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk); idle(); mem_req = 1;
      expect_out($sformatf("to_wait%0d", i), S_MEM, 0, 0, 0, 32'd0);
      check($sformatf("to_err_low%0d", i), 64'(mem_err), 64'd0);
    end
    @(negedge clk); idle(); mem_req = 1;
    expect_out("err_stall", S_MEM, 0, 0, 0, 32'd0);
    check("err_set", 64'(mem_err), 64'd1);
    // ERROR ignores ready and branches.
    @(negedge clk); idle(); mem_req = 1; mem_ready = 1;
    ex_branch_taken = 1; ex_branch_target = 32'h300;
    expect_out("err_hold", S_MEM, 0, 0, 0, 32'd0);
    check("err_sticky", 64'(mem_err), 64'd1);
    check("err_stall_cnt", 64'(stall_cnt), 64'd11);
    check("err_flush_cnt", 64'(flush_cnt), 64'd2);

    // One reset cycle recovers to RUN with everything cleared.
    @(negedge clk); rst = 1; idle();
    expect_out("rst2_mask", 6'd0, 0, 0, 0, 32'd0);
    @(negedge clk); rst = 0;
    expect_out("rst2_idle", 6'd0, 0, 0, 0, 32'd0);
    check("rst2_mem_err", 64'(mem_err), 64'd0);
    check("rst2_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst2_flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk); idle(); ex_branch_taken = 1; ex_branch_target = 32'h444;
    expect_out("rst2_branch", 6'd0, 1, 1, 1, 32'h444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
